led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter: DIV_W, 19, width of tick prescaler reload and counter.
REQ-002 Parameter: STEP_W, 8, width of step-limit input and step counter.
REQ-003 Port: clk  in  1  clock, all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: i_start  in  1  sampled per cycle, starts a sequence from IDLE.
REQ-006 Port: i_stop  in  1  sampled per cycle, aborts any active sequence.
REQ-007 Port: i_pause  in  1  level, freezes tick counter while high in RUN.
REQ-008 Port: i_mode  in  2  00 rotate-left, 01 rotate-right, 10 ping-pong, 11 reserved.
REQ-009 Port: i_div  in  DIV_W  tick reload; tick period = i_div+1 cycles.
REQ-010 Port: i_steps  in  STEP_W  shift count before done; 0 = run until stop.
REQ-011 Port: i_pattern  in  8  initial LED pattern.
REQ-012 Port: o_led  out  8  LED pattern, registered, bit 7 = MSB.
REQ-013 Port: o_busy  out  1  high in every state except IDLE.
REQ-014 Port: o_done  out  1  one-cycle pulse on step-limit completion.

Function
REQ-015 FSM states IDLE, LOAD, RUN, SHIFT, DONE; invalid encoding -> IDLE next cycle.
REQ-016 IDLE: o_led <= i_pattern each cycle; i_start=1 and i_stop=0 -> LOAD.
REQ-017 LOAD (1 cycle): capture i_mode, i_div, i_steps, i_pattern into shadow regs; tick counter <= i_div; step counter <= 0; direction <= left; -> RUN.
REQ-018 Inputs other than i_stop/i_pause are ignored outside IDLE/LOAD; i_start while busy has no effect.
REQ-019 RUN: i_pause=0 -> counter decrements; counter==0 -> SHIFT and counter <= shadow div; i_pause=1 -> counter holds.
REQ-020 SHIFT (1 cycle): o_led updated per mode; step counter +1; if shadow steps!=0 and new count==shadow steps -> DONE, else -> RUN.
REQ-021 Rotate-left: o_led <= {o_led[6:0],o_led[7]}; rotate-right: o_led <= {o_led[0],o_led[7:1]}; mode 11 behaves as rotate-left.
REQ-022 Ping-pong: direction flips before shifting when moving left with o_led[7]=1 or moving right with o_led[0]=1; shift is logical in new direction, zero fill.
REQ-023 DONE (1 cycle): o_done=1, o_led holds; -> IDLE.
REQ-024 i_stop=1 in LOAD/RUN/SHIFT/DONE -> IDLE next cycle, no o_done, no shift that cycle; stop has priority over tick, pause and done.
REQ-025 Step counter wraps modulo 2^STEP_W when shadow steps==0; no effect on output.
REQ-026 i_div=0 -> SHIFT every second cycle (RUN,SHIFT alternation).

Reset
REQ-027 rst=1 -> state IDLE, o_led=8'h00, o_busy=0, o_done=0, counters 0, direction left; effective immediately, mid-sequence included.

Configuration
REQ-028 Macro LED_SEQ_PINGPONG_EN defined: mode 10 = ping-pong per REQ-022.
REQ-029 Macro undefined: no direction register or bounce logic; mode 10 behaves as rotate-left.

Structure
REQ-030 Shared package led_seq_pkg holds state enum, mode encodings (MODE_ROL, MODE_ROR, MODE_PP, MODE_RSV), default DIV_W/STEP_W.
REQ-031 Sub-module led_tick_gen holds prescaler counter (load, enable, tick out); FSM and shifter remain in led_seq_ctrl.

Verification
REQ-032 i_pattern=8'hFE, mode 00, div=3, steps=2, start pulse -> o_led FD at SHIFT1, FB at SHIFT2, 4 cycles apart; o_done pulses once; IDLE.
REQ-033 mode 01, pattern 8'h01, steps=0 -> o_led 80,40,20... continuous; i_stop in RUN -> IDLE next cycle, o_done never asserted.
REQ-034 PINGPONG_EN, pattern 8'h40, div=0 -> o_led 80,40,20; without macro -> 80,01,02.
REQ-035 div=2, i_pause high 10 cycles in RUN -> no shift during pause; tick spacing resumes with remaining count.
REQ-036 rst asserted in SHIFT -> o_led=00, o_busy=0 same cycle; i_start while busy -> no restart, sequence unaffected.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and encodings for the LED sequencer: FSM states, mode codes,
// default widths and the fixed 8-bit rotate helpers.
package led_seq_pkg;

  localparam int DEF_DIV_W  = 19;
  localparam int DEF_STEP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_ROR = 2'b01;
  localparam logic [1:0] MODE_PP  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] v);
    return {v[0], v[7:1]};
  endfunction

endpackage

// File: rtl/led_seq_ctrl_tick.sv
// Prescaler for the LED sequencer: loadable down-counter that reloads itself
// from the value captured at load time whenever it is enabled at zero.
module led_tick_gen
  import led_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= (cnt == '0) ? reload_q : cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      reload_q <= load_val;
    end
  end

  // Terminal count; the owner decides whether this cycle actually consumes it.
  assign tick = (cnt == '0);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: FSM plus shifter around the led_tick_gen prescaler.
// Optional build macro LED_SEQ_PINGPONG_EN enables the ping-pong mode (10).
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause,
  input  logic [1:0]        i_mode,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [STEP_W-1:0] i_steps,
  input  logic [7:0]        i_pattern,
  output logic [7:0]        o_led,
  output logic              o_busy,
  output logic              o_done
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        mode_q;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_inc;
  logic [7:0]        led_q;
  logic [7:0]        led_shift;
  logic              cnt_load;
  logic              cnt_en;
  logic              tick;
  logic              load_go;
  logic              shift_go;

  // The prescaler also runs during SHIFT so that shifts land i_div+1 cycles
  // apart; with i_div=0 the RUN/SHIFT alternation gives the 2-cycle minimum.
  led_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (i_div),
    .en       (cnt_en),
    .tick     (tick)
  );

  assign step_inc = step_cnt + STEP_W'(1);

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    load_go   = 1'b0;
    shift_go  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start && !i_stop) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (i_stop) begin
          state_nxt = ST_IDLE;
        end else begin
          load_go   = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          state_nxt = ST_IDLE;
        end else if (!i_pause) begin
          cnt_en = 1'b1;
          if (tick) state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_stop) begin
          state_nxt = ST_IDLE;
        end else begin
          shift_go = 1'b1;
          cnt_en   = 1'b1;
          if ((steps_q != '0) && (step_inc == steps_q)) state_nxt = ST_DONE;
          else                                          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef LED_SEQ_PINGPONG_EN
  logic dir_right_q;
  logic dir_right_nxt;

  always_comb begin
    dir_right_nxt = dir_right_q;
    led_shift     = rotl8(led_q);
    case (mode_q)
      MODE_ROR: led_shift = rotr8(led_q);
      MODE_PP: begin
        // Bounce off the end bit first, then shift logically the new way.
        if (!dir_right_q && led_q[7])     dir_right_nxt = 1'b1;
        else if (dir_right_q && led_q[0]) dir_right_nxt = 1'b0;
        led_shift = dir_right_nxt ? {1'b0, led_q[7:1]} : {led_q[6:0], 1'b0};
      end
      MODE_ROL, MODE_RSV: led_shift = rotl8(led_q);
      default: led_shift = rotl8(led_q);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_right_q <= 1'b0;
    end else if (load_go) begin
      dir_right_q <= 1'b0;
    end else if (shift_go) begin
      dir_right_q <= dir_right_nxt;
    end
  end
`else
  always_comb begin
    led_shift = rotl8(led_q);
    case (mode_q)
      MODE_ROR:                    led_shift = rotr8(led_q);
      MODE_ROL, MODE_PP, MODE_RSV: led_shift = rotl8(led_q);
      default:                     led_shift = rotl8(led_q);
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      led_q    <= 8'h00;
      step_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) || load_go) led_q <= i_pattern;
      else if (shift_go)                 led_q <= led_shift;
      if (load_go)       step_cnt <= '0;
      else if (shift_go) step_cnt <= step_inc;
    end
  end

  // Shadow copies are only read after LOAD has written them.
  always_ff @(posedge clk) begin
    if (load_go) begin
      mode_q  <= i_mode;
      steps_q <= i_steps;
    end
  end

  assign o_led  = led_q;
  assign o_busy = (state != ST_IDLE);
  assign o_done = (state == ST_DONE) && !i_stop;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed sequences with literal
// expectations plus randomized traffic against a timeline-level model.
module tb_led_seq_ctrl;

  localparam int DIV_W  = 19;
  localparam int STEP_W = 8;

  logic              clk;
  logic              rst;
  logic              i_start;
  logic              i_stop;
  logic              i_pause;
  logic [1:0]        i_mode;
  logic [DIV_W-1:0]  i_div;
  logic [STEP_W-1:0] i_steps;
  logic [7:0]        i_pattern;
  logic [7:0]        o_led;
  logic              o_busy;
  logic              o_done;

  led_seq_ctrl #(
    .DIV_W  (DIV_W),
    .STEP_W (STEP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .i_pause   (i_pause),
    .i_mode    (i_mode),
    .i_div     (i_div),
    .i_steps   (i_steps),
    .i_pattern (i_pattern),
    .o_led     (o_led),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Timeline model: idle -> armed -> waiting N un-paused cycles -> shift
  // -> waiting ... ; shifts are div+1 cycles apart (at least 2).
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_WAIT  = 2;
  localparam int M_SHIFT = 3;
  localparam int M_DONE  = 4;

  int          ph = M_IDLE;
  int unsigned m_led = 0;
  int unsigned m_wait = 0;
  int unsigned m_nsh = 0;
  int unsigned s_div = 0;
  int unsigned s_steps = 0;
  int unsigned s_mode = 0;
  bit          m_right = 1'b0;

  function automatic int unsigned shift_model(input int unsigned x, input int unsigned mode,
                                              inout bit right);
    if (mode == 1) return (x >> 1) | ((x & 1) << 7);
`ifdef LED_SEQ_PINGPONG_EN
    if (mode == 2) begin
      if (!right && x >= 128)   right = 1'b1;
      else if (right && (x & 1) != 0) right = 1'b0;
      return right ? (x >> 1) : ((x << 1) & 255);
    end
`endif
    return ((x << 1) & 255) | (x >> 7);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ph = M_IDLE;
        m_led = 0;
      end else begin
        case (ph)
          M_IDLE: begin
            m_led = i_pattern;
            if (i_start && !i_stop) ph = M_ARMED;
          end
          M_ARMED: begin
            if (i_stop) ph = M_IDLE;
            else begin
              s_mode = i_mode; s_div = i_div; s_steps = i_steps;
              m_led = i_pattern; m_right = 1'b0; m_nsh = 0;
              m_wait = s_div + 1;
              ph = M_WAIT;
            end
          end
          M_WAIT: begin
            if (i_stop) ph = M_IDLE;
            else if (!i_pause) begin
              m_wait--;
              if (m_wait == 0) ph = M_SHIFT;
            end
          end
          M_SHIFT: begin
            if (i_stop) ph = M_IDLE;
            else begin
              m_led = shift_model(m_led, s_mode, m_right);
              m_nsh = (m_nsh + 1) % (1 << STEP_W);
              m_wait = (s_div == 0) ? 1 : s_div;
              ph = (s_steps != 0 && m_nsh == s_steps) ? M_DONE : M_WAIT;
            end
          end
          default: ph = M_IDLE;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_led", {24'h0, o_led}, m_led);
      chk("model_busy", {31'h0, o_busy}, {31'h0, ph != M_IDLE});
      chk("model_done", {31'h0, o_done}, {31'h0, (ph == M_DONE) && !i_stop});
    end
  end

  logic [7:0] hist [0:31];
  bit         dn   [0:31];
  bit         bz   [0:31];

  task automatic sample(input int i);
    @(negedge clk);
    hist[i] = o_led;
    dn[i]   = o_done;
    bz[i]   = o_busy;
  endtask

  task automatic launch(input logic [7:0] pat, input logic [1:0] mode,
                        input int div, input int steps);
    i_pattern = pat;
    i_mode    = mode;
    i_div     = DIV_W'(div);
    i_steps   = STEP_W'(steps);
    i_start   = 1'b1;
  endtask

  task automatic settle();
    i_stop = 1'b1;
    @(negedge clk); #1;
    i_stop = 1'b0;
    @(negedge clk); #1;
  endtask

  function automatic int done_count(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) c += dn[k];
    return c;
  endfunction

  initial begin
    rst = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_pause = 1'b0;
    i_mode = 2'b00; i_div = '0; i_steps = '0; i_pattern = 8'h00;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_led", {24'h0, o_led}, 32'h00);
    chk("reset_busy", {31'h0, o_busy}, 32'h0);
    chk("reset_done", {31'h0, o_done}, 32'h0);
    #1 rst = 1'b0;

    // Rotate-left, two steps, with a start pulse while busy.
    launch(8'hFE, 2'b00, 3, 2);
    for (int i = 1; i <= 14; i++) begin
      sample(i); #1;
      if (i == 1) i_start = 1'b0;
      if (i == 3) i_start = 1'b1;
      if (i == 4) i_start = 1'b0;
    end
    chk("rol_busy_load", {31'h0, bz[1]}, 32'h1);
    chk("rol_pre_shift", {24'h0, hist[6]}, 32'hFE);
    chk("rol_shift1", {24'h0, hist[7]}, 32'hFD);
    chk("rol_hold", {24'h0, hist[10]}, 32'hFD);
    chk("rol_shift2", {24'h0, hist[11]}, 32'hFB);
    chk("rol_done_pulse", {31'h0, dn[11]}, 32'h1);
    chk("rol_done_count", done_count(14), 32'd1);
    chk("rol_idle_after", {31'h0, bz[12]}, 32'h0);
    settle();

    // Rotate-right, unlimited, stopped in RUN.
    launch(8'h01, 2'b01, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      sample(i); #1;
      if (i == 1) i_start = 1'b0;
      if (i == 9) i_stop = 1'b1;
    end
    i_stop = 1'b0;
    chk("ror_1", {24'h0, hist[5]}, 32'h80);
    chk("ror_2", {24'h0, hist[7]}, 32'h40);
    chk("ror_3", {24'h0, hist[9]}, 32'h20);
    chk("ror_stop_hold", {24'h0, hist[10]}, 32'h20);
    chk("ror_stop_busy", {31'h0, bz[10]}, 32'h0);
    chk("ror_no_done", done_count(10), 32'd0);
    settle();

    // Mode 10 with div=0.
    launch(8'h40, 2'b10, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      sample(i); #1;
      if (i == 1) i_start = 1'b0;
      if (i == 8) i_stop = 1'b1;
    end
    i_stop = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
    chk("pp_1", {24'h0, hist[4]}, 32'h80);
    chk("pp_2", {24'h0, hist[6]}, 32'h40);
    chk("pp_3", {24'h0, hist[8]}, 32'h20);
`else
    chk("m10_1", {24'h0, hist[4]}, 32'h80);
    chk("m10_2", {24'h0, hist[6]}, 32'h01);
    chk("m10_3", {24'h0, hist[8]}, 32'h02);
`endif
    settle();

    // Pause for ten cycles mid-count.
    launch(8'h01, 2'b00, 2, 0);
    for (int i = 1; i <= 20; i++) begin
      sample(i); #1;
      if (i == 1)  i_start = 1'b0;
      if (i == 6)  i_pause = 1'b1;
      if (i == 16) i_pause = 1'b0;
      if (i == 19) i_stop = 1'b1;
    end
    i_stop = 1'b0;
    chk("pause_pre", {24'h0, hist[5]}, 32'h01);
    chk("pause_shift1", {24'h0, hist[6]}, 32'h02);
    chk("pause_frozen", {24'h0, hist[9]}, 32'h02);
    chk("pause_resume_wait", {24'h0, hist[18]}, 32'h02);
    chk("pause_shift2", {24'h0, hist[19]}, 32'h04);
    settle();

    // Asynchronous reset while in SHIFT.
    launch(8'hFE, 2'b00, 3, 2);
    for (int i = 1; i <= 6; i++) begin
      sample(i); #1;
      if (i == 1) i_start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("rst_shift_led", {24'h0, o_led}, 32'h00);
    chk("rst_shift_busy", {31'h0, o_busy}, 32'h0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      i_start   = ($urandom_range(0, 5) == 0);
      i_stop    = ($urandom_range(0, 29) == 0);
      i_pause   = ($urandom_range(0, 4) == 0);
      i_mode    = 2'($urandom_range(0, 3));
      i_div     = DIV_W'($urandom_range(0, 4));
      i_steps   = STEP_W'($urandom_range(0, 5));
      i_pattern = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
      end
    end

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
